mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the shared 16x8 data RAM (4-bit address, 8-bit signed data, rw/clr controls, out_valid return). Port 0 is the CPU control unit; port 1 is the debug/loader port. Each requester gets a req/ack handshake. The block serialises accesses with round-robin fairness, handles read-valid waiting with a timeout, and sequences a full-memory clear on request.

Parameters:
TIMEOUT, 8, max cycles to wait for mem_out_valid on a read before aborting (1..255)
CLR_CYCLES, 2, cycles mem_clr is held high for a clear operation (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 request; hold with fields stable until ack0
rw0  in  1  port 0 direction, 1=write, 0=read
addr0  in  4  port 0 address
wdata0  in  8  port 0 write data
ack0  out  1  one-cycle completion pulse to port 0
rdata0  out  8  port 0 read data, valid with ack0
req1, rw1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
err  out  1  pulses with ack when a read timed out
clr_req  in  1  level request to clear the memory
clr_done  out  1  one-cycle pulse when the clear completes
busy  out  1  high whenever state != IDLE
grant_id  out  1  port currently or last served
mem_rw  out  1  to RAM, 1=write
mem_clr  out  1  to RAM clear
mem_address  out  4  to RAM
mem_data_in  out  8  to RAM
mem_data_out  in  8  from RAM
mem_out_valid  in  1  from RAM, read data valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; last-served pointer=1 so port 0 wins the first tie; timeout and clear counters=0.
- Reset mid-operation aborts the transaction. No ack is issued and no RAM write completes after reset assertion.
- All outputs are registered.
- States are IDLE, ISSUE, WAIT_RD, RESP, CLEAR.
- IDLE, priority order: clr_req, then requests.
  - clr_req=1: go to CLEAR.
  - Exactly one req: grant it.
  - Both req: grant the port opposite to last served.
  - On grant: latch rw/addr/wdata, set grant_id, go to ISSUE.
- ISSUE (1 cycle): mem_address=addr and mem_rw=rw; mem_data_in=wdata for writes.
  - Write: go to RESP.
  - Read: go to WAIT_RD and clear the timeout counter.
- WAIT_RD: mem_rw=0 and address is held.
  - mem_out_valid=1: capture mem_data_out and go to RESP.
  - Counter reaches TIMEOUT without valid: go to RESP with rdata=0 and err=1.
- RESP (1 cycle): the granted port's ack=1, its rdata is updated (reads only), and err reflects the timeout. Update last-served, go to IDLE.
- The non-granted port's ack and rdata are untouched.
- Outside ISSUE and WAIT_RD: mem_rw=0 and mem_data_in=0. mem_address holds its last value.
- Latency, with req sampled high in IDLE cycle 0:
  - Write: RAM write strobe in cycle 1, ack in cycle 2.
  - Read: if valid is seen in cycle k (k>=2), ack is in cycle k+1.
- A req held high after its ack is treated as a new transaction. It re-arbitrates in the next IDLE, and round-robin prevents starvation of the other port.
- Dropping req before ack is illegal; the arbiter completes the latched transaction regardless.
- CLEAR: mem_clr=1 for CLR_CYCLES cycles, then mem_clr=0, clr_done pulses 1 cycle, and state returns to IDLE.
- clr_req is only sampled in IDLE, so a clear never interrupts a transaction.
- A clr_req still high after clr_done triggers another clear; the requester drops it on clr_done.
- busy=1 in every state except IDLE.

Test Plan:
1. Port 0 write 0x5A to addr 3, then read addr 3 -> mem_rw=1 in cycle 1 with mem_address=3 and mem_data_in=0x5A; ack0 in cycle 2; the read returns rdata0=0x5A with ack0; ack1 never asserts.
2. req0 and req1 both held high for 4 transactions (reads of addr 1 and 2) -> grants alternate 0,1,0,1 starting with port 0; each ack is a 1-cycle pulse.
3. Read with mem_out_valid forced low, TIMEOUT=8 -> RESP after 8 WAIT_RD cycles; ack1=1, err=1, rdata1=0; next transaction proceeds normally.
4. clr_req raised during a port 1 read -> read completes first; then mem_clr is high for exactly CLR_CYCLES=2 cycles; clr_done pulses; a subsequent read of addr 3 returns 0x00.
5. rst_n pulsed low during WAIT_RD (asynchronous, mid-cycle) -> all outputs 0 immediately; no ack; after release, port 0 wins the first tie.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared 16x8 data RAM.
// Serialises reads and writes, times out stalled reads, and runs full-memory clears.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 8,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       rw0,
    input  logic [3:0] addr0,
    input  logic [7:0] wdata0,
    output logic       ack0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       rw1,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata1,
    output logic       ack1,
    output logic [7:0] rdata1,
    output logic       err,
    input  logic       clr_req,
    output logic       clr_done,
    output logic       busy,
    output logic       grant_id,
    output logic       mem_rw,
    output logic       mem_clr,
    output logic [3:0] mem_address,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out,
    input  logic       mem_out_valid
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, RESP, CLEAR} state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       rw_q, rw_d;
    logic [7:0] tmo_q, tmo_d;
    logic [3:0] clr_cnt_q, clr_cnt_d;

    logic       ack0_q, ack0_d, ack1_q, ack1_d;
    logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic       err_q, err_d, clr_done_q, clr_done_d, busy_q, busy_d;
    logic       grant_id_q, grant_id_d, mem_rw_q, mem_rw_d, mem_clr_q, mem_clr_d;
    logic [3:0] mem_address_q, mem_address_d;
    logic [7:0] mem_data_in_q, mem_data_in_d;

    logic       sel;
    logic       resp_go, resp_rd, resp_err;
    logic [7:0] resp_data;

    // Outputs are registered, so each one is computed from the transition being taken.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        rw_d          = rw_q;
        tmo_d         = tmo_q;
        clr_cnt_d     = clr_cnt_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        err_d         = 1'b0;
        clr_done_d    = 1'b0;
        mem_rw_d      = 1'b0;
        mem_clr_d     = 1'b0;
        mem_data_in_d = '0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        grant_id_d    = grant_id_q;
        mem_address_d = mem_address_q;
        sel           = 1'b0;
        resp_go       = 1'b0;
        resp_rd       = 1'b0;
        resp_err      = 1'b0;
        resp_data     = '0;

        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    mem_clr_d = 1'b1;
                    clr_cnt_d = '0;
                end else if (req0 || req1) begin
                    sel           = (req0 && req1) ? ~last_q : req1;
                    grant_id_d    = sel;
                    rw_d          = sel ? rw1 : rw0;
                    mem_address_d = sel ? addr1 : addr0;
                    mem_rw_d      = rw_d;
                    mem_data_in_d = rw_d ? (sel ? wdata1 : wdata0) : '0;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (rw_q) begin
                    resp_go = 1'b1;
                end else begin
                    state_d = WAIT_RD;
                    tmo_d   = '0;
                end
            end
            WAIT_RD: begin
                if (mem_out_valid) begin
                    resp_go   = 1'b1;
                    resp_rd   = 1'b1;
                    resp_data = mem_data_out;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    resp_go  = 1'b1;
                    resp_rd  = 1'b1;
                    resp_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            RESP: begin
                last_d  = grant_id_q;
                state_d = IDLE;
            end
            CLEAR: begin
                // Extra final cycle carries clr_done so a requester dropping on it avoids a repeat clear.
                if (clr_cnt_q == 4'(CLR_CYCLES)) begin
                    state_d = IDLE;
                end else if (clr_cnt_q == 4'(CLR_CYCLES - 1)) begin
                    clr_done_d = 1'b1;
                    clr_cnt_d  = clr_cnt_q + 4'd1;
                end else begin
                    mem_clr_d = 1'b1;
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (resp_go) begin
            state_d = RESP;
            err_d   = resp_err;
            if (grant_id_q) begin
                ack1_d = 1'b1;
                if (resp_rd) rdata1_d = resp_data;
            end else begin
                ack0_d = 1'b1;
                if (resp_rd) rdata0_d = resp_data;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            rw_q          <= 1'b0;
            tmo_q         <= '0;
            clr_cnt_q     <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            err_q         <= 1'b0;
            clr_done_q    <= 1'b0;
            busy_q        <= 1'b0;
            grant_id_q    <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_clr_q     <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            rw_q          <= rw_d;
            tmo_q         <= tmo_d;
            clr_cnt_q     <= clr_cnt_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            err_q         <= err_d;
            clr_done_q    <= clr_done_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            mem_rw_q      <= mem_rw_d;
            mem_clr_q     <= mem_clr_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign err         = err_q;
    assign clr_done    = clr_done_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign mem_rw      = mem_rw_q;
    assign mem_clr     = mem_clr_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16x8 RAM that returns
// read data one cycle after the address is presented.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, rw0, req1, rw1, clr_req;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, err, clr_done, busy, grant_id, mem_rw, mem_clr;
    logic [7:0] rdata0, rdata1, mem_data_in, mem_data_out;
    logic [3:0] mem_address;
    logic       mem_out_valid = 1'b0;
    logic       valid_en;
    logic [7:0] ram [16];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(8), .CLR_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .err(err), .clr_req(clr_req), .clr_done(clr_done), .busy(busy), .grant_id(grant_id),
        .mem_rw(mem_rw), .mem_clr(mem_clr), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_out_valid(mem_out_valid)
    );

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
        end else if (mem_rw) begin
            ram[mem_address] <= mem_data_in;
        end
        mem_out_valid <= valid_en && busy && !mem_rw && !mem_clr;
        mem_data_out  <= ram[mem_address];
    end

    function automatic logic [63:0] outvec();
        return 64'({ack0, ack1, rdata0, rdata1, err, clr_done, busy, grant_id,
                    mem_rw, mem_clr, mem_address, mem_data_in});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on port p; returns latency in cycles from the IDLE request cycle.
    task automatic txn(input logic p, input logic rw, input logic [3:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output logic e, output logic other,
                       output logic rw_c1, output logic [3:0] a_c1, output logic [7:0] d_c1);
        logic got;
        @(negedge clk);
        if (p) begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
        lat = 0; got = 1'b0; other = 1'b0; rd = '0; e = 1'b0;
        rw_c1 = 1'b0; a_c1 = '0; d_c1 = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin rw_c1 = mem_rw; a_c1 = mem_address; d_c1 = mem_data_in; end
            if (p ? ack0 : ack1) other = 1'b1;
            if (p ? ack1 : ack0) begin
                got = 1'b1;
                rd  = p ? rdata1 : rdata0;
                e   = err;
            end
        end
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, cnt;
        logic [7:0] rd, d1;
        logic [3:0] a1;
        logic       e, other, r1, seen;
        logic [1:0] who;

        rst_n = 1'b0; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0; clr_req = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; valid_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", outvec(), 64'd0);
        rst_n = 1'b1;

        // Port 0 write 0x5A to addr 3, then read it back.
        txn(1'b0, 1'b1, 4'd3, 8'h5A, lat, rd, e, other, r1, a1, d1);
        chk("wr_latency", 64'(lat), 64'd2);
        chk("wr_strobe_c1", 64'(r1), 64'd1);
        chk("wr_addr_c1", 64'(a1), 64'd3);
        chk("wr_data_c1", 64'(d1), 64'h5A);
        chk("wr_resp_memrw_din", 64'({mem_rw, mem_data_in, mem_address}), 64'h003);
        txn(1'b0, 1'b0, 4'd3, 8'h00, lat, rd, e, other, r1, a1, d1);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_data", 64'(rd), 64'h5A);
        chk("rd_err", 64'(e), 64'd0);
        chk("rd_no_ack1", 64'(other), 64'd0);

        txn(1'b1, 1'b1, 4'd1, 8'h11, lat, rd, e, other, r1, a1, d1);
        txn(1'b1, 1'b1, 4'd2, 8'h22, lat, rd, e, other, r1, a1, d1);
        chk("p1_wr_latency", 64'(lat), 64'd2);
        chk("p1_grant_id", 64'(grant_id), 64'd1);

        // Both ports held: grants alternate starting with port 0.
        @(negedge clk);
        req0 = 1; rw0 = 0; addr0 = 4'd1; req1 = 1; rw1 = 0; addr1 = 4'd2;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 20 && !(ack0 || ack1); i++) @(negedge clk);
            who = {ack0, ack1};
            chk($sformatf("rr_grant_%0d", t), 64'(who), (t % 2 == 0) ? 64'd2 : 64'd1);
            chk($sformatf("rr_data_%0d", t), 64'((t % 2 == 0) ? rdata0 : rdata1),
                (t % 2 == 0) ? 64'h11 : 64'h22);
            if (t == 3) begin req0 = 0; req1 = 0; end
            @(negedge clk);
            chk($sformatf("rr_pulse_%0d", t), 64'({ack0, ack1}), 64'd0);
        end

        // Read timeout with valid suppressed, then a normal read.
        valid_en = 1'b0;
        txn(1'b1, 1'b0, 4'd5, 8'h00, lat, rd, e, other, r1, a1, d1);
        chk("tmo_latency", 64'(lat), 64'd10);
        chk("tmo_err", 64'(e), 64'd1);
        chk("tmo_rdata", 64'(rd), 64'd0);
        valid_en = 1'b1;
        txn(1'b1, 1'b0, 4'd2, 8'h00, lat, rd, e, other, r1, a1, d1);
        chk("post_tmo_latency", 64'(lat), 64'd3);
        chk("post_tmo_data", 64'(rd), 64'h22);
        chk("post_tmo_err", 64'(e), 64'd0);

        // Clear requested mid-read: the read completes first.
        @(negedge clk);
        req1 = 1; rw1 = 0; addr1 = 4'd1;
        @(negedge clk);
        clr_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !ack1; i++) begin
            @(negedge clk);
            if (mem_clr) seen = 1'b1;
        end
        req1 = 1'b0;
        chk("clr_rd_ack", 64'(ack1), 64'd1);
        chk("clr_rd_data", 64'(rdata1), 64'h11);
        chk("clr_not_early", 64'(seen), 64'd0);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_clr) cnt++;
            if (clr_done) begin
                seen = 1'b1;
                clr_req = 1'b0;
                chk("clr_done_no_clr", 64'(mem_clr), 64'd0);
            end
        end
        chk("clr_cycles", 64'(cnt), 64'd2);
        chk("clr_done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        chk("clr_after", 64'({clr_done, mem_clr, busy}), 64'd0);
        txn(1'b0, 1'b0, 4'd3, 8'h00, lat, rd, e, other, r1, a1, d1);
        chk("clr_rd_addr3", 64'(rd), 64'h00);
        chk("clr_rd_latency", 64'(lat), 64'd3);

        // Asynchronous reset during WAIT_RD.
        valid_en = 1'b0;
        @(negedge clk);
        req1 = 1; rw1 = 0; addr1 = 4'd9;
        repeat (3) @(negedge clk);
        chk("pre_rst_state", 64'({busy, grant_id, mem_address}), 64'h39);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outputs", outvec(), 64'd0);
        req0 = 1; rw0 = 0; addr0 = 4'd3; addr1 = 4'd2;
        valid_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_held_outputs", outvec(), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !(ack0 || ack1); i++) @(negedge clk);
        chk("post_rst_tie", 64'({ack0, ack1}), 64'd2);
        req0 = 0; req1 = 0;
        @(negedge clk);
        chk("post_rst_pulse", 64'({ack0, ack1}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
